wb_queue: RTL
=============

Name: wb_queue

Overview:
- Write-side front end for the 32x32 integer register file. It sits between the writeback sources (ALU and load results) and the register file's single write port.
- Buffers writeback requests in a small in-order FIFO and drains at most one entry per cycle onto the regfile write port (rd_addr/rd_data/rd_wren).
- Provides a youngest-match bypass for the two decode read addresses. Values still queued are therefore visible before they reach the register file.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_wb_valid  input  1  writeback request valid.
- i_wb_addr  input  5  destination register index.
- i_wb_data  input  32  destination value.
- o_wb_ready  output  1  queue can accept a request this cycle.
- i_drain_en  input  1  regfile write port available this cycle.
- o_rd_addr  output  5  regfile write address (queue head).
- o_rd_data  output  32  regfile write data (queue head).
- o_rd_wren  output  1  regfile write enable.
- i_rs1_addr  input  5  decode read address 1.
- i_rs2_addr  input  5  decode read address 2.
- o_rs1_hit  output  1  rs1 matches a queued entry.
- o_rs1_data  output  32  youngest queued value for rs1.
- o_rs2_hit  output  1  rs2 matches a queued entry.
- o_rs2_data  output  32  youngest queued value for rs2.
- o_count  output  CNT_W  current occupancy.
- o_empty  output  1  occupancy == 0.

Behaviour:
- Storage: DEPTH entries {addr[4:0], data[31:0], valid}, plus head pointer, tail pointer and count.
- Reset (i_rst high, any time, asynchronous):
  - Pointers, count and all entry valid bits clear immediately.
  - Outputs while in reset: o_count=0, o_empty=1, o_wb_ready=1, o_rd_wren=0, hits=0.
  - Data outputs while in reset: o_rd_addr=0, o_rd_data=0, o_rsX_data=0.
  - Reset mid-drain discards all queued entries. No regfile write occurs on the reset edge.
- o_wb_ready = (count != DEPTH). It is combinational and does not depend on i_wb_valid.
  - When full, no push is accepted, even if a pop occurs in the same cycle (no pass-through).
- Push: happens when i_wb_valid && o_wb_ready at the clock edge.
  - i_wb_addr != 0: entry is written at tail, tail advances mod DEPTH, count+1.
  - i_wb_addr == 0: request is accepted (handshake completes) and discarded; queue state is unchanged.
- Pop/drain: o_rd_wren = !o_empty && i_drain_en, combinational.
  - o_rd_addr/o_rd_data always show the head entry; both are 0 when empty.
  - The regfile captures the head on the same edge. Head then advances mod DEPTH and count-1.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Bypass (combinational):
  - rsX hits when rsX != 0 and any valid entry's addr == rsX.
  - o_rsX_data is the youngest matching entry, i.e. the one closest to tail; otherwise 0.
  - The entry being drained this cycle remains bypass-visible until the edge.
  - The request being pushed this cycle is not visible until the next cycle.
- Ordering: strictly FIFO. Multiple queued writes to the same register drain in order, so the regfile ends with the youngest value.
- Pointer wrap-around: head and tail wrap from DEPTH-1 to 0. Full is distinguished from empty by count, not by pointer equality.

Test Plan:
- Reset: assert i_rst mid-cycle with 2 entries queued -> immediately o_count=0, o_empty=1, o_rd_wren=0; after release o_wb_ready=1.
- Fill and stall: i_drain_en=0; push x1=0x11, x2=0x22, x3=0x33, x4=0x44 -> o_count=4, o_wb_ready=0; a 5th push of x5 is not accepted; then i_drain_en=1 -> writes x1, x2, x3, x4 on 4 consecutive cycles, then o_empty=1.
- x0 drop: push addr 0, data 0xDEAD -> ready handshake completes, o_count stays 0, o_rd_wren never asserts; i_rs1_addr=0 -> o_rs1_hit=0.
- Youngest bypass: i_drain_en=0; push x5=0xA, then x5=0xB -> i_rs1_addr=5 gives hit=1, data=0xB; i_rs2_addr=6 gives hit=0, data=0; after draining both, the last regfile write to x5 is 0xB.
- Simultaneous push/pop at count=2 over 6 cycles crossing wrap -> count stays 2; the drain sequence equals the push sequence with no loss or duplication.
- Same-cycle visibility: push x7=0x77 with i_rs1_addr=7 in that cycle -> o_rs1_hit=0; next cycle -> hit=1, data=0x77.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue in front of the regfile write port.
// Youngest-match bypass exposes queued values to the decode read ports.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_addr,
  input  logic [31:0]      i_wb_data,
  output logic             o_wb_ready,
  input  logic             i_drain_en,
  output logic [4:0]       o_rd_addr,
  output logic [31:0]      o_rd_data,
  output logic             o_rd_wren,
  input  logic [4:0]       i_rs1_addr,
  input  logic [4:0]       i_rs2_addr,
  output logic             o_rs1_hit,
  output logic [31:0]      o_rs1_data,
  output logic             o_rs2_hit,
  output logic [31:0]      o_rs2_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // x0 writes complete the handshake but never occupy an entry
  assign push = i_wb_valid && !full
             && (i_wb_addr != 5'd0);
  assign pop  = !empty && i_drain_en;

  assign o_wb_ready = !full;
  assign o_rd_wren  = pop;
  assign o_count    = count_q;
  assign o_empty    = empty;
  assign o_rd_addr  = empty ? 5'd0
                            : addr_q[head_q];
  assign o_rd_data  = empty ? 32'd0
                            : data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)
      head_d = head_q + 1'b1;
    if (push)
      tail_d = tail_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last match wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    o_rs1_hit  = 1'b0;
    o_rs1_data = 32'd0;
    o_rs2_hit  = 1'b0;
    o_rs2_data = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (vld_q[idx]
          && i_rs1_addr != 5'd0
          && addr_q[idx] == i_rs1_addr) begin
        o_rs1_hit  = 1'b1;
        o_rs1_data = data_q[idx];
      end
      if (vld_q[idx]
          && i_rs2_addr != 5'd0
          && addr_q[idx] == i_rs2_addr) begin
        o_rs2_hit  = 1'b1;
        o_rs2_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop)
        vld_q[head_q] <= 1'b0;
      if (push) begin
        vld_q[tail_q]  <= 1'b1;
        addr_q[tail_q] <= i_wb_addr;
        data_q[tail_q] <= i_wb_data;
      end
    end
  end

endmodule
